e203_icb_arb2: RTL
==================

Name: e203_icb_arb2

Overview:
- Two-master to one-slave ICB arbiter.
- It lets two requesters share one system ICB target, for example sysmem or sysper: two initiators feed one target port of the e203 subsystem.
- Commands are arbitrated round-robin with lock-until-accept.
- Responses are returned in order to the issuing master, using an outstanding-ID FIFO.

Parameters:
- AW, 32, command address width.
- DW, 32, data width (wmask is DW/8).
- OUTS_DEPTH, 2, maximum number of outstanding commands; power of 2, ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- mN_icb_cmd_valid  in  1  master N command valid (N=0,1; this applies to every mN_ line)
- mN_icb_cmd_ready  out  1  master N command accepted
- mN_icb_cmd_addr  in  AW  address
- mN_icb_cmd_read  in  1  1=read, 0=write
- mN_icb_cmd_wdata  in  DW  write data
- mN_icb_cmd_wmask  in  DW/8  byte enables
- mN_icb_rsp_valid  out  1  response valid to master N
- mN_icb_rsp_ready  in  1  master N accepts response
- mN_icb_rsp_err  out  1  response error
- mN_icb_rsp_rdata  out  DW  read data
- s_icb_cmd_valid  out  1  slave command valid
- s_icb_cmd_ready  in  1  slave accepts command
- s_icb_cmd_addr/read/wdata/wmask  out  AW/1/DW/DW/8  muxed command fields
- s_icb_rsp_valid  in  1  slave response valid
- s_icb_rsp_ready  out  1  arbiter accepts response
- s_icb_rsp_err  in  1  slave error
- s_icb_rsp_rdata  in  DW  slave read data
- unexp_rsp  out  1  sticky flag: slave sent a response while nothing was outstanding

Behaviour:
- Reset is asynchronous on rst. Reset values:
  - rr_ptr=0, so m0 has priority first.
  - lock_vld=0.
  - FIFO empty (count=0).
  - unexp_rsp=0.
- Under reset, all outputs are 0, apart from field muxes whose value is don't-care. Reset asserted mid-transaction drops all outstanding state; masters must also be reset.
- Grant (combinational, zero added command latency):
  - If lock_vld=1, grant lock_id.
  - Otherwise, if only one master is valid, grant that master.
  - Otherwise, if both are valid, grant the master not equal to rr_ptr.
  - Otherwise, no grant.
- Command gating:
  - s_icb_cmd_valid = granted master's valid & !fifo_full.
  - mG_icb_cmd_ready = s_icb_cmd_ready & !fifo_full.
  - The non-granted master's ready is 0.
  - Command fields are muxed from the granted master.
- Lock rule:
  - If s_icb_cmd_valid=1 and s_icb_cmd_ready=0, then on the next cycle lock_vld←1 and lock_id←grant.
  - lock_vld clears on the handshake.
  - Masters must hold valid once raised; the arbiter never withdraws s_icb_cmd_valid before the handshake.
  - If fifo_full blocks a valid master, no lock is taken, and arbitration is re-evaluated each cycle.
- Command handshake (s_icb_cmd_valid & s_icb_cmd_ready):
  - push grant ID into the FIFO;
  - rr_ptr←grant.
- Response routing:
  - head = FIFO head ID.
  - If FIFO not empty: m[head]_icb_rsp_valid = s_icb_rsp_valid; the other master's rsp_valid = 0; s_icb_rsp_ready = m[head]_icb_rsp_ready.
  - err and rdata are broadcast to both masters; they are qualified only by the valid line.
- Response handshake: pop the FIFO.
- Empty FIFO with s_icb_rsp_valid=1:
  - s_icb_rsp_ready=0;
  - unexp_rsp←1 next cycle; it stays set until rst.
- FIFO:
  - circular, with rd/wr pointers of log2(OUTS_DEPTH) bits that wrap;
  - count of log2(OUTS_DEPTH)+1 bits.
  - Push and pop in the same cycle leaves count unchanged.
  - When full, push is blocked even if a pop occurs the same cycle; the command is accepted next cycle.
- Same-cycle response-to-command: a command accepted in cycle T may receive its response at T+1 at the earliest; a same-cycle response is not supported.

Test Plan:
- Single master, no contention:
  - Stimulus: m0 write addr=0x8000_0000, wdata=0xDEAD_BEEF, wmask=0xF; slave always ready; response 1 cycle later.
  - Required: s_icb_cmd fields equal m0's fields in the same cycle; m0_icb_rsp_valid=1 at T+1; m1_icb_rsp_valid=0.
- Round-robin:
  - Stimulus: both masters valid continuously; slave ready every cycle.
  - Required: grants alternate m1, m0, m1, m0 starting after reset (rr_ptr=0 gives m1 first); each master gets 50%.
- Lock:
  - Stimulus: m0 valid; s_icb_cmd_ready=0 for 3 cycles; m1 raises valid in cycle 1.
  - Required: m0 stays granted with stable fields until ready=1; m1 is granted on the following cycle.
- FIFO full backpressure (OUTS_DEPTH=2):
  - Stimulus: issue 3 reads with no response.
  - Required: the 3rd read is held with cmd_ready=0. After one response returns to the first issuer, the 3rd read is accepted the next cycle.
- In-order routing:
  - Stimulus: m0 read, then m1 read; responses rdata=0x11 then 0x22; m0 holds rsp_ready=0 for 2 cycles.
  - Required: 0x11 goes to m0 only after m0's ready; 0x22 goes to m1 afterwards; s_icb_rsp_ready follows the head master's ready.
- Unexpected response and reset:
  - Stimulus: s_icb_rsp_valid=1 with FIFO empty.
  - Required: s_icb_rsp_ready=0; unexp_rsp=1 next cycle. Asserting rst asynchronously clears unexp_rsp, the FIFO and the lock immediately.

Source files
------------

// File: rtl/e203_icb_arb2.sv
// ---------------------------------------------------------------------------
// e203_icb_arb2 : two-master to one-slave ICB arbiter.
//
// Two initiators share one ICB target. Commands are granted round-robin.
// Once a command has been offered to the slave and stalled, the grant locks
// on that master until the command is accepted. The ID of every accepted
// command goes into a small FIFO, and responses are routed back in order to
// the master at the FIFO head.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   mN_icb_cmd_*      command channel of master N (N = 0, 1)
//   mN_icb_rsp_*      response channel of master N
//   s_icb_cmd_*       muxed command channel to the slave
//   s_icb_rsp_*       response channel from the slave
//   unexp_rsp         sticky flag: slave responded with nothing outstanding
// ---------------------------------------------------------------------------
module e203_icb_arb2 #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int OUTS_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  // master 0
  input  logic            m0_icb_cmd_valid,
  output logic            m0_icb_cmd_ready,
  input  logic [AW-1:0]   m0_icb_cmd_addr,
  input  logic            m0_icb_cmd_read,
  input  logic [DW-1:0]   m0_icb_cmd_wdata,
  input  logic [DW/8-1:0] m0_icb_cmd_wmask,
  output logic            m0_icb_rsp_valid,
  input  logic            m0_icb_rsp_ready,
  output logic            m0_icb_rsp_err,
  output logic [DW-1:0]   m0_icb_rsp_rdata,
  // master 1
  input  logic            m1_icb_cmd_valid,
  output logic            m1_icb_cmd_ready,
  input  logic [AW-1:0]   m1_icb_cmd_addr,
  input  logic            m1_icb_cmd_read,
  input  logic [DW-1:0]   m1_icb_cmd_wdata,
  input  logic [DW/8-1:0] m1_icb_cmd_wmask,
  output logic            m1_icb_rsp_valid,
  input  logic            m1_icb_rsp_ready,
  output logic            m1_icb_rsp_err,
  output logic [DW-1:0]   m1_icb_rsp_rdata,
  // slave
  output logic            s_icb_cmd_valid,
  input  logic            s_icb_cmd_ready,
  output logic [AW-1:0]   s_icb_cmd_addr,
  output logic            s_icb_cmd_read,
  output logic [DW-1:0]   s_icb_cmd_wdata,
  output logic [DW/8-1:0] s_icb_cmd_wmask,
  input  logic            s_icb_rsp_valid,
  output logic            s_icb_rsp_ready,
  input  logic            s_icb_rsp_err,
  input  logic [DW-1:0]   s_icb_rsp_rdata,
  output logic            unexp_rsp
);

  // A depth of 1 still needs a 1-bit pointer; wrap is handled explicitly.
  localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int CW = $clog2(OUTS_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(OUTS_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] LAST_PTR = PW'(OUTS_DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic                  r_rr_ptr;
  logic                  r_lock_vld;
  logic                  r_lock_id;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [OUTS_DEPTH-1:0] r_fifo_id;
  logic                  r_unexp_rsp;

  logic          w_grant_vld;
  logic          w_grant_id;
  logic          w_grant_mvalid;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_head_id;
  logic          w_cmd_hsk;
  logic          w_rsp_hsk;
  logic [PW-1:0] w_wr_ptr_nxt;
  logic [PW-1:0] w_rd_ptr_nxt;

  assign w_fifo_full  = (r_count == FULL_CNT);
  assign w_fifo_empty = (r_count == {CW{1'b0}});
  assign w_head_id    = r_fifo_id[r_rd_ptr];
  assign w_cmd_hsk    = s_icb_cmd_valid & s_icb_cmd_ready;
  assign w_rsp_hsk    = s_icb_rsp_valid & s_icb_rsp_ready;
  assign unexp_rsp    = r_unexp_rsp;

  // Grant selection: a stalled command keeps its grant, else round-robin.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = 1'b0;
    if (r_lock_vld) begin
      w_grant_vld = 1'b1;
      w_grant_id  = r_lock_id;
    end else if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
      // rr_ptr holds the last winner, so the other master goes next.
      w_grant_vld = 1'b1;
      w_grant_id  = ~r_rr_ptr;
    end else if (m0_icb_cmd_valid) begin
      w_grant_vld = 1'b1;
      w_grant_id  = 1'b0;
    end else if (m1_icb_cmd_valid) begin
      w_grant_vld = 1'b1;
      w_grant_id  = 1'b1;
    end else begin
      w_grant_vld = 1'b0;
      w_grant_id  = 1'b0;
    end
  end

  // Valid of the currently granted master.
  always_comb begin
    w_grant_mvalid = 1'b0;
    if (w_grant_id) begin
      w_grant_mvalid = m1_icb_cmd_valid;
    end else begin
      w_grant_mvalid = m0_icb_cmd_valid;
    end
  end

  // Command valid/ready gating; a full FIFO stalls both sides of the handshake.
  always_comb begin
    s_icb_cmd_valid  = 1'b0;
    m0_icb_cmd_ready = 1'b0;
    m1_icb_cmd_ready = 1'b0;
    if (!rst && w_grant_vld) begin
      s_icb_cmd_valid = w_grant_mvalid & ~w_fifo_full;
      if (w_grant_id) begin
        m1_icb_cmd_ready = s_icb_cmd_ready & ~w_fifo_full;
      end else begin
        m0_icb_cmd_ready = s_icb_cmd_ready & ~w_fifo_full;
      end
    end else begin
      s_icb_cmd_valid = 1'b0;
    end
  end

  // Command field mux from the granted master.
  always_comb begin
    s_icb_cmd_addr  = m0_icb_cmd_addr;
    s_icb_cmd_read  = m0_icb_cmd_read;
    s_icb_cmd_wdata = m0_icb_cmd_wdata;
    s_icb_cmd_wmask = m0_icb_cmd_wmask;
    if (w_grant_id) begin
      s_icb_cmd_addr  = m1_icb_cmd_addr;
      s_icb_cmd_read  = m1_icb_cmd_read;
      s_icb_cmd_wdata = m1_icb_cmd_wdata;
      s_icb_cmd_wmask = m1_icb_cmd_wmask;
    end else begin
      s_icb_cmd_addr  = m0_icb_cmd_addr;
      s_icb_cmd_read  = m0_icb_cmd_read;
      s_icb_cmd_wdata = m0_icb_cmd_wdata;
      s_icb_cmd_wmask = m0_icb_cmd_wmask;
    end
  end

  // Response routing to the master at the FIFO head; nothing is accepted when empty.
  always_comb begin
    m0_icb_rsp_valid = 1'b0;
    m1_icb_rsp_valid = 1'b0;
    s_icb_rsp_ready  = 1'b0;
    if (!w_fifo_empty) begin
      if (w_head_id) begin
        m1_icb_rsp_valid = s_icb_rsp_valid;
        s_icb_rsp_ready  = m1_icb_rsp_ready;
      end else begin
        m0_icb_rsp_valid = s_icb_rsp_valid;
        s_icb_rsp_ready  = m0_icb_rsp_ready;
      end
    end else begin
      s_icb_rsp_ready = 1'b0;
    end
  end

  // Response payload is broadcast; only the valid line selects the receiver.
  always_comb begin
    m0_icb_rsp_err   = 1'b0;
    m1_icb_rsp_err   = 1'b0;
    m0_icb_rsp_rdata = {DW{1'b0}};
    m1_icb_rsp_rdata = {DW{1'b0}};
    if (!rst) begin
      m0_icb_rsp_err   = s_icb_rsp_err;
      m1_icb_rsp_err   = s_icb_rsp_err;
      m0_icb_rsp_rdata = s_icb_rsp_rdata;
      m1_icb_rsp_rdata = s_icb_rsp_rdata;
    end else begin
      m0_icb_rsp_err = 1'b0;
    end
  end

  // Wrapping next-pointer values for the ID FIFO.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
    w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
    if (r_wr_ptr == LAST_PTR) begin
      w_wr_ptr_nxt = {PW{1'b0}};
    end else begin
      w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
    end
    if (r_rd_ptr == LAST_PTR) begin
      w_rd_ptr_nxt = {PW{1'b0}};
    end else begin
      w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
    end
  end

  // Round-robin pointer and lock-until-accept state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr   <= 1'b0;
      r_lock_vld <= 1'b0;
      r_lock_id  <= 1'b0;
    end else if (w_cmd_hsk) begin
      r_rr_ptr   <= w_grant_id;
      r_lock_vld <= 1'b0;
    end else if (s_icb_cmd_valid) begin
      // Offered but stalled: pin the grant so the slave sees a stable command.
      r_lock_vld <= 1'b1;
      r_lock_id  <= w_grant_id;
    end else begin
      r_lock_vld <= r_lock_vld;
    end
  end

  // Outstanding-ID FIFO: push on command handshake, pop on response handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= {PW{1'b0}};
      r_rd_ptr  <= {PW{1'b0}};
      r_count   <= {CW{1'b0}};
      r_fifo_id <= {OUTS_DEPTH{1'b0}};
    end else begin
      if (w_cmd_hsk) begin
        r_fifo_id[r_wr_ptr] <= w_grant_id;
        r_wr_ptr            <= w_wr_ptr_nxt;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_rsp_hsk) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_cmd_hsk, w_rsp_hsk})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flag for a response arriving with nothing outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_unexp_rsp <= 1'b0;
    end else if (s_icb_rsp_valid && w_fifo_empty) begin
      r_unexp_rsp <= 1'b1;
    end else begin
      r_unexp_rsp <= r_unexp_rsp;
    end
  end

endmodule
